// File: rtl/oversampler_phase_tracker_pkg.sv
// =============================================================================
// oversampler_phase_tracker_pkg : shared types and width helpers  (rev 1.0)
// =============================================================================
`default_nettype none

package oversampler_phase_tracker_pkg;

   // Bit 0 = late hit, bit 1 = early hit.
   typedef enum logic [1:0] {
      HIT_NONE  = 2'b00,
      HIT_LATE  = 2'b01,
      HIT_EARLY = 2'b10,
      HIT_BOTH  = 2'b11
   } hit_e;

   function automatic int pw_f(input int nphases);
      return (nphases > 1) ? $clog2(nphases) : 1;
   endfunction

   function automatic int vw_f(input int thresh);
      return $clog2(thresh) + 2;
   endfunction

   function automatic int lw_f(input int lock_cycles);
      return (lock_cycles > 0) ? $clog2(lock_cycles + 1) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/oversampler_phase_tracker_ch.sv
// =============================================================================
// oversampler_phase_tracker_ch : one channel, sample stage + phase/vote/lock  (rev 1.0)
// =============================================================================
`default_nettype none

module oversampler_phase_tracker_ch
   import oversampler_phase_tracker_pkg::*;
#(
   parameter int NPHASES          = 4,
   parameter int BITS             = 2,
   parameter int THRESH           = 4,
   parameter int LOCK_CYCLES      = 1024,
   parameter int PHASE_SEL_MANUAL = 0,
   localparam int S  = BITS * NPHASES,
   localparam int PW = pw_f(NPHASES),
   localparam int VW = vw_f(THRESH),
   localparam int LW = lw_f(LOCK_CYCLES)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [S-1:0]  samples,
   input  logic [PW-1:0] phase_sel_in,
   output logic [PW-1:0] phase_sel_out,
   output logic [BITS-1:0] d_o,
   output logic          phase_err,
   output logic          slip_late,
   output logic          slip_early,
   output logic          locked
);

   localparam logic signed [VW-1:0] V_UP_LAST = VW'(THRESH - 1);
   localparam logic signed [VW-1:0] V_DN_LAST = VW'(1 - THRESH);
   localparam logic signed [VW-1:0] V_ONE     = VW'(1);
   localparam logic [PW-1:0]        P_ONE     = PW'(1);
   localparam logic [PW-1:0]        P_LAST    = PW'(NPHASES - 1);
   localparam logic [LW-1:0]        L_ONE     = LW'(1);
   localparam logic [LW-1:0]        L_MAX     = LW'(LOCK_CYCLES);

   logic [S-1:0]           s_q;
   logic                   last_q;
   logic [PW-1:0]          p_q, p_n;
   logic signed [VW-1:0]   v_q, v_n;
   logic [LW-1:0]          lock_q, lock_n;
   logic [BITS-1:0]        d_q, d_n;
   logic                   err_q, err_n;
   logic                   sl_q, sl_n;
   logic                   se_q, se_n;

   logic [S-1:0]           edges;
   logic [NPHASES-1:0]     fold;
   logic [NPHASES-1:0]     ui_word;
   logic [PW-1:0]          p_inc, p_dec;
   logic                   late, early;
   hit_e                   hit;

   // Transition map across the word, seeded with the last sample of the previous word.
   assign edges = s_q ^ {s_q[S-2:0], last_q};

   always_comb begin
      fold = '0;
      for (int i = 0; i < BITS; i++) begin
         fold = fold | edges[i*NPHASES +: NPHASES];
      end
   end

   // NPHASES is a power of two, so phase arithmetic wraps for free.
   assign p_inc = p_q + P_ONE;
   assign p_dec = p_q - P_ONE;
   assign late  = fold[p_q];
   assign early = fold[p_inc];
   assign hit   = hit_e'({early, late});

   always_comb begin
      d_n     = '0;
      ui_word = '0;
      for (int i = 0; i < BITS; i++) begin
         ui_word = s_q[i*NPHASES +: NPHASES];
         d_n[i]  = ui_word[p_q];
      end
   end

   always_comb begin
      p_n   = p_q;
      v_n   = v_q;
      sl_n  = 1'b0;
      se_n  = 1'b0;
      err_n = late & early;
      if (PHASE_SEL_MANUAL != 0) begin
         p_n = phase_sel_in;
         v_n = '0;
      end else begin
         case (hit)
            HIT_LATE: begin
               if (v_q == V_UP_LAST) begin
                  v_n  = '0;
                  p_n  = p_inc;
                  sl_n = (p_q == P_LAST);
               end else begin
                  v_n = v_q + V_ONE;
               end
            end
            HIT_EARLY: begin
               if (v_q == V_DN_LAST) begin
                  v_n  = '0;
                  p_n  = p_dec;
                  se_n = (p_q == '0);
               end else begin
                  v_n = v_q - V_ONE;
               end
            end
            default: v_n = v_q;
         endcase
      end

      if ((p_n != p_q) || err_n) begin
         lock_n = '0;
      end else if (lock_q != L_MAX) begin
         lock_n = lock_q + L_ONE;
      end else begin
         lock_n = lock_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s_q    <= '0;
         last_q <= 1'b0;
         p_q    <= '0;
         v_q    <= '0;
         lock_q <= '0;
         d_q    <= '0;
         err_q  <= 1'b0;
         sl_q   <= 1'b0;
         se_q   <= 1'b0;
      end else begin
         s_q    <= samples;
         last_q <= s_q[S-1];
         p_q    <= p_n;
         v_q    <= v_n;
         lock_q <= lock_n;
         d_q    <= d_n;
         err_q  <= err_n;
         sl_q   <= sl_n;
         se_q   <= se_n;
      end
   end

   assign phase_sel_out = p_q;
   assign d_o           = d_q;
   assign phase_err     = err_q;
   assign slip_late     = sl_q;
   assign slip_early    = se_q;
   assign locked        = (lock_q == L_MAX);

endmodule

`default_nettype wire

// File: rtl/oversampler_phase_tracker.sv
// =============================================================================
// oversampler_phase_tracker : NCH independent phase-tracking channels  (rev 1.0)
// =============================================================================
`default_nettype none

module oversampler_phase_tracker
   import oversampler_phase_tracker_pkg::*;
#(
   parameter int NCH              = 1,
   parameter int NPHASES          = 4,
   parameter int BITS             = 2,
   parameter int THRESH           = 4,
   parameter int LOCK_CYCLES      = 1024,
   parameter int PHASE_SEL_MANUAL = 0,
   localparam int S  = BITS * NPHASES,
   localparam int PW = pw_f(NPHASES)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NCH*S-1:0]  samples_i,
   input  logic [NCH*PW-1:0] phase_sel_in,
   output logic [NCH*PW-1:0] phase_sel_out,
   output logic [NCH*BITS-1:0] d_o,
   output logic [NCH-1:0]    phase_err,
   output logic [NCH-1:0]    slip_late,
   output logic [NCH-1:0]    slip_early,
   output logic [NCH-1:0]    locked
);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      oversampler_phase_tracker_ch #(
         .NPHASES          (NPHASES),
         .BITS             (BITS),
         .THRESH           (THRESH),
         .LOCK_CYCLES      (LOCK_CYCLES),
         .PHASE_SEL_MANUAL (PHASE_SEL_MANUAL)
      ) u_ch (
         .clock         (clock),
         .reset         (reset),
         .samples       (samples_i[c*S +: S]),
         .phase_sel_in  (phase_sel_in[c*PW +: PW]),
         .phase_sel_out (phase_sel_out[c*PW +: PW]),
         .d_o           (d_o[c*BITS +: BITS]),
         .phase_err     (phase_err[c]),
         .slip_late     (slip_late[c]),
         .slip_early    (slip_early[c]),
         .locked        (locked[c])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_oversampler_phase_tracker.sv
// =============================================================================
// tb_oversampler_phase_tracker : auto and manual instances against a reference model  (rev 1.0)
// =============================================================================
`default_nettype none

module tb_oversampler_phase_tracker;

   localparam int NCH    = 2;
   localparam int NP     = 4;
   localparam int BITS   = 2;
   localparam int THRESH = 4;
   localparam int LOCK   = 16;
   localparam int S      = BITS * NP;
   localparam int PW     = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [NCH*S-1:0]    samples_i = '0;
   logic [NCH*PW-1:0]   sel_in    = '0;

   logic [NCH*PW-1:0]   pso_a, pso_m;
   logic [NCH*BITS-1:0] d_a, d_m;
   logic [NCH-1:0]      err_a, err_m, sl_a, sl_m, se_a, se_m, lk_a, lk_m;

   always #5 clock = ~clock;

   oversampler_phase_tracker #(
      .NCH(NCH), .NPHASES(NP), .BITS(BITS), .THRESH(THRESH),
      .LOCK_CYCLES(LOCK), .PHASE_SEL_MANUAL(0)
   ) dut_a (
      .clock(clock), .reset(reset), .samples_i(samples_i), .phase_sel_in(sel_in),
      .phase_sel_out(pso_a), .d_o(d_a), .phase_err(err_a),
      .slip_late(sl_a), .slip_early(se_a), .locked(lk_a)
   );

   oversampler_phase_tracker #(
      .NCH(NCH), .NPHASES(NP), .BITS(BITS), .THRESH(THRESH),
      .LOCK_CYCLES(LOCK), .PHASE_SEL_MANUAL(1)
   ) dut_m (
      .clock(clock), .reset(reset), .samples_i(samples_i), .phase_sel_in(sel_in),
      .phase_sel_out(pso_m), .d_o(d_m), .phase_err(err_m),
      .slip_late(sl_m), .slip_early(se_m), .locked(lk_m)
   );

   typedef struct {
      int p;
      int v;
      int lc;
      bit l;
   } st_t;

   typedef struct packed {
      logic [NCH*PW-1:0]   pso;
      logic [NCH*BITS-1:0] d;
      logic [NCH-1:0]      err;
      logic [NCH-1:0]      sl;
      logic [NCH-1:0]      se;
      logic [NCH-1:0]      lk;
   } exp_t;

   exp_t q_a[$];
   exp_t q_m[$];
   st_t  st_a[NCH];
   st_t  st_m[NCH];
   logic [NCH*S-1:0] prev_word = '0;
   bit   cur_bit[NCH];

   int n_tests = 0;
   int n_fail  = 0;
   bit started  = 1'b0;
   bit rst_seen = 1'b1;

   // One edge of a channel: reads the word held in the sample stage, returns the next state.
   function automatic st_t step(input st_t st, input logic [S-1:0] w, input bit man, input int sel,
                                output logic [BITS-1:0] d, output logic err,
                                output logic sl, output logic se);
      st_t n;
      bit  t[NP];
      bit  prevb;
      bit  late, early;
      n = st;
      prevb = st.l;
      for (int k = 0; k < NP; k++) t[k] = 1'b0;
      for (int j = 0; j < S; j++) begin
         if (w[j] != prevb) t[j % NP] = 1'b1;
         prevb = w[j];
      end
      late  = t[st.p];
      early = t[(st.p + 1) % NP];
      for (int i = 0; i < BITS; i++) d[i] = w[i*NP + st.p];
      err = late && early;
      sl  = 1'b0;
      se  = 1'b0;
      if (man) begin
         n.p = sel;
         n.v = 0;
      end else begin
         if (late && !early)      n.v = st.v + 1;
         else if (early && !late) n.v = st.v - 1;
         if (n.v == THRESH) begin
            n.v = 0;
            n.p = (st.p + 1) % NP;
            sl  = (st.p == NP - 1);
         end else if (n.v == -THRESH) begin
            n.v = 0;
            n.p = (st.p + NP - 1) % NP;
            se  = (st.p == 0);
         end
      end
      if (n.p != st.p || err) n.lc = 0;
      else if (st.lc < LOCK)  n.lc = st.lc + 1;
      n.l = w[S-1];
      return n;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         st_a[c] = '{p: 0, v: 0, lc: 0, l: 1'b0};
         st_m[c] = '{p: 0, v: 0, lc: 0, l: 1'b0};
      end
      prev_word = '0;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   // Drive one word; the edge it is captured on also runs stage 2 on the previous word.
   task automatic drive(input logic [NCH*S-1:0] w, input logic [NCH*PW-1:0] sel);
      exp_t ea, em;
      logic [BITS-1:0] d;
      logic err, sl, se;
      samples_i = w;
      sel_in    = sel;
      for (int c = 0; c < NCH; c++) begin
         st_a[c] = step(st_a[c], prev_word[c*S +: S], 1'b0, int'(sel[c*PW +: PW]), d, err, sl, se);
         ea.d[c*BITS +: BITS] = d;
         ea.err[c] = err; ea.sl[c] = sl; ea.se[c] = se;
         ea.pso[c*PW +: PW] = PW'(st_a[c].p);
         ea.lk[c] = (st_a[c].lc == LOCK);
         st_m[c] = step(st_m[c], prev_word[c*S +: S], 1'b1, int'(sel[c*PW +: PW]), d, err, sl, se);
         em.d[c*BITS +: BITS] = d;
         em.err[c] = err; em.sl[c] = sl; em.se[c] = se;
         em.pso[c*PW +: PW] = PW'(st_m[c].p);
         em.lk[c] = (st_m[c].lc == LOCK);
      end
      q_a.push_back(ea);
      q_m.push_back(em);
      prev_word = w;
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      samples_i = NCH*S'($urandom);
      model_reset();
      repeat (cycles) begin
         @(posedge clock);
         #2;
      end
      reset = 1'b0;
   endtask

   // Eye generator: within each UI the data changes at sample index off.
   task automatic gen(input int off0, input int off1, input bit noise, output logic [NCH*S-1:0] w);
      int off;
      bit nb;
      w = '0;
      for (int c = 0; c < NCH; c++) begin
         off = (c == 0) ? off0 : off1;
         if (noise) begin
            w[c*S +: S] = S'($urandom);
         end else begin
            for (int i = 0; i < BITS; i++) begin
               nb = 1'($urandom_range(0, 1));
               for (int j = 0; j < NP; j++) w[c*S + i*NP + j] = (j < off) ? cur_bit[c] : nb;
               cur_bit[c] = nb;
            end
         end
      end
   endtask

   always @(posedge clock) begin
      rst_seen <= reset;
      started  <= 1'b1;
   end

   // Monitor: outputs are valid every cycle; reset edges must show all-zero outputs.
   always @(negedge clock) begin
      exp_t ea, em;
      if (started) begin
         if (rst_seen) begin
            check("reset_auto", 32'({pso_a, d_a, err_a, sl_a, se_a, lk_a}), 32'd0);
            check("reset_man",  32'({pso_m, d_m, err_m, sl_m, se_m, lk_m}), 32'd0);
         end else if (q_a.size() == 0 || q_m.size() == 0) begin
            check("scoreboard_underflow", 32'(q_a.size() + q_m.size()), 32'd2);
         end else begin
            ea = q_a.pop_front();
            em = q_m.pop_front();
            check("auto_phase",  32'(pso_a), 32'(ea.pso));
            check("auto_data",   32'(d_a),   32'(ea.d));
            check("auto_err",    32'(err_a), 32'(ea.err));
            check("auto_slip_l", 32'(sl_a),  32'(ea.sl));
            check("auto_slip_e", 32'(se_a),  32'(ea.se));
            check("auto_locked", 32'(lk_a),  32'(ea.lk));
            check("man_phase",   32'(pso_m), 32'(em.pso));
            check("man_data",    32'(d_m),   32'(em.d));
            check("man_err",     32'(err_m), 32'(em.err));
            check("man_slip_l",  32'(sl_m),  32'(em.sl));
            check("man_slip_e",  32'(se_m),  32'(em.se));
            check("man_locked",  32'(lk_m),  32'(em.lk));
         end
      end
   end

   initial begin
      logic [NCH*S-1:0]  w;
      logic [NCH*PW-1:0] sel;
      cur_bit[0] = 1'b0;
      cur_bit[1] = 1'b1;
      do_reset(3);

      // Steady eye and steady manual selection {2,1}: both instances should lock.
      for (int n = 0; n < 60; n++) begin
         gen(2, 1, 1'b0, w);
         drive(w, {2'd2, 2'd1});
      end
      // Eye drifting later: phase walks forward and wraps with slip_late.
      for (int n = 0; n < 128; n++) begin
         gen((2 + n/16) % NP, (3 + n/16) % NP, 1'b0, w);
         sel = NCH*PW'($urandom);
         drive(w, sel);
      end
      // Eye drifting earlier: phase walks backward and wraps with slip_early.
      for (int n = 0; n < 128; n++) begin
         gen((256 + 2 - n/16) % NP, (256 + 1 - n/16) % NP, 1'b0, w);
         sel = (n % 8 == 0) ? NCH*PW'($urandom) : sel;
         drive(w, sel);
      end
      // Alternating late/early hits, then a narrow/noisy eye.
      for (int n = 0; n < 40; n++) begin
         gen((n % 2 == 0) ? 1 : 3, (n % 2 == 0) ? 0 : 2, 1'b0, w);
         drive(w, {2'd2, 2'd1});
      end
      for (int n = 0; n < 40; n++) begin
         gen(0, 0, 1'b1, w);
         drive(w, NCH*PW'($urandom));
      end
      // Mid-stream reset, then relock.
      do_reset(1 + $urandom_range(0, 2));
      for (int n = 0; n < 50; n++) begin
         gen(1, 3, 1'b0, w);
         drive(w, {2'd1, 2'd3});
      end

      @(negedge clock);
      #1;
      check("scoreboard_drained", 32'(q_a.size() + q_m.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
